// File: rtl/shot_sequencer_if.sv
// rtl/shot_sequencer_if.sv - button/power inputs and game display outputs of shot_sequencer
// Ports (master = driver of buttons, slave = shot_sequencer):
//   btn_fire, btn_left, btn_right, power[1:0]         master -> slave
//   tank1_loc[3:0], tank2_loc[3:0], shell[7:0], turn,  slave -> master
//   busy, hit_pulse, lives1[1:0], lives2[1:0], game_over, winner
interface shot_sequencer_if;
    logic       btn_fire;
    logic       btn_left;
    logic       btn_right;
    logic [1:0] power;
    logic [3:0] tank1_loc;
    logic [3:0] tank2_loc;
    logic [7:0] shell;
    logic       turn;
    logic       busy;
    logic       hit_pulse;
    logic [1:0] lives1;
    logic [1:0] lives2;
    logic       game_over;
    logic       winner;

    modport master (
        output btn_fire, btn_left, btn_right, power,
        input  tank1_loc, tank2_loc, shell, turn, busy, hit_pulse,
               lives1, lives2, game_over, winner
    );

    modport slave (
        input  btn_fire, btn_left, btn_right, power,
        output tank1_loc, tank2_loc, shell, turn, busy, hit_pulse,
               lives1, lives2, game_over, winner
    );
endinterface

// File: rtl/shot_sequencer.sv
// rtl/shot_sequencer.sv - round controller for the two-tank artillery game on an 8-position field
// Ports: clk, nrst (async active-low), bus (shot_sequencer_if.slave: buttons and power in,
//        tank locations, shell, turn, busy, hit_pulse, lives, game_over, winner out).
// Tank 1 lives on field positions 7..4, tank 2 on 3..0. All outputs are registered.
module shot_sequencer #(
    parameter int STEP_CYCLES = 512,
    parameter int LIVES       = 3
) (
    input  logic            clk,
    input  logic            nrst,
    shot_sequencer_if.slave bus
);
    localparam int             TW         = $clog2(STEP_CYCLES);
    localparam logic [TW-1:0]  STEP_LAST  = TW'(STEP_CYCLES - 1);
    localparam logic [1:0]     LIVES_INIT = 2'(LIVES);
    localparam logic [3:0]     T1_HOME    = 4'b1000;
    localparam logic [3:0]     T2_HOME    = 4'b0001;
    localparam logic [7:0]     SHELL_HOME = 8'b0100_0000;

    typedef enum logic [1:0] {AIM, FLIGHT, IMPACT, OVER} state_t;

    state_t          state_q, state_d;
    logic [3:0]      t1_q, t1_d, t2_q, t2_d;
    logic [7:0]      shell_q, shell_d;
    logic            turn_q, turn_d;
    logic            busy_q, busy_d;
    logic            hit_q, hit_d;
    logic [1:0]      lives1_q, lives1_d, lives2_q, lives2_d;
    logic            over_q, over_d;
    logic            winner_q, winner_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      trav_q, trav_d;
    logic [2:0]      dist_q, dist_d;
    logic [7:0]      opp_loc;
    logic [1:0]      opp_lives;
    logic            is_hit;

    // Shell spot right in front of the active tank's barrel, as an 8-bit field vector.
    function automatic logic [7:0] adjacent(input logic who, input logic [3:0] l1, input logic [3:0] l2);
        logic [7:0] v;
        v = who ? ({4'b0000, l2} << 1) : ({l1, 4'b0000} >> 1);
        return v;
    endfunction

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= AIM;
            t1_q     <= T1_HOME;
            t2_q     <= T2_HOME;
            shell_q  <= SHELL_HOME;
            turn_q   <= 1'b0;
            busy_q   <= 1'b0;
            hit_q    <= 1'b0;
            lives1_q <= LIVES_INIT;
            lives2_q <= LIVES_INIT;
            over_q   <= 1'b0;
            winner_q <= 1'b0;
            timer_q  <= '0;
            trav_q   <= '0;
            dist_q   <= '0;
        end else begin
            state_q  <= state_d;
            t1_q     <= t1_d;
            t2_q     <= t2_d;
            shell_q  <= shell_d;
            turn_q   <= turn_d;
            busy_q   <= busy_d;
            hit_q    <= hit_d;
            lives1_q <= lives1_d;
            lives2_q <= lives2_d;
            over_q   <= over_d;
            winner_q <= winner_d;
            timer_q  <= timer_d;
            trav_q   <= trav_d;
            dist_q   <= dist_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        t1_d      = t1_q;
        t2_d      = t2_q;
        shell_d   = shell_q;
        turn_d    = turn_q;
        hit_d     = 1'b0;
        lives1_d  = lives1_q;
        lives2_d  = lives2_q;
        winner_d  = winner_q;
        timer_d   = timer_q;
        trav_d    = trav_q;
        dist_d    = dist_q;
        opp_loc   = turn_q ? {t1_q, 4'b0000} : {4'b0000, t2_q};
        opp_lives = turn_q ? lives1_q : lives2_q;
        is_hit    = (shell_q != 8'd0) && (shell_q == opp_loc);

        case (state_q)
            AIM: begin
                if (bus.btn_fire) begin
                    // Fire has priority; a simultaneous move is dropped.
                    dist_d  = {1'b0, bus.power} + 3'd2;
                    trav_d  = 3'd1;
                    timer_d = '0;
                    state_d = FLIGHT;
                end else if (bus.btn_left || bus.btn_right) begin
                    if (!turn_q) begin
                        if (bus.btn_left) begin
                            if (!t1_q[0]) t1_d = t1_q >> 1;
                        end else if (!t1_q[3]) begin
                            t1_d = t1_q << 1;
                        end
                    end else begin
                        if (bus.btn_left) begin
                            if (!t2_q[0]) t2_d = t2_q >> 1;
                        end else if (!t2_q[3]) begin
                            t2_d = t2_q << 1;
                        end
                    end
                    shell_d = adjacent(turn_q, t1_d, t2_d);
                end
            end
            FLIGHT: begin
                if (timer_q == STEP_LAST) begin
                    timer_d = '0;
                    if (trav_q == dist_q) begin
                        state_d = IMPACT;
                    end else begin
                        trav_d  = trav_q + 3'd1;
                        // Shifting a one-hot past either end leaves zero, which is the off-field encoding.
                        shell_d = turn_q ? (shell_q << 1) : (shell_q >> 1);
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            IMPACT: begin
                if (is_hit && opp_lives != 2'd0) begin
                    hit_d = 1'b1;
                    if (turn_q) lives1_d = lives1_q - 2'd1;
                    else        lives2_d = lives2_q - 2'd1;
                end
                if (is_hit && opp_lives == 2'd1) begin
                    state_d  = OVER;
                    winner_d = turn_q;
                    shell_d  = 8'd0;
                end else begin
                    state_d = AIM;
                    turn_d  = ~turn_q;
                    shell_d = adjacent(~turn_q, t1_q, t2_q);
                end
            end
            OVER: begin
                if (bus.btn_fire) begin
                    state_d  = AIM;
                    t1_d     = T1_HOME;
                    t2_d     = T2_HOME;
                    shell_d  = SHELL_HOME;
                    turn_d   = 1'b0;
                    lives1_d = LIVES_INIT;
                    lives2_d = LIVES_INIT;
                    winner_d = 1'b0;
                    timer_d  = '0;
                    trav_d   = '0;
                    dist_d   = '0;
                end
            end
            default: state_d = AIM;
        endcase

        busy_d = (state_d == FLIGHT) || (state_d == IMPACT);
        over_d = (state_d == OVER);
    end

    assign bus.tank1_loc = t1_q;
    assign bus.tank2_loc = t2_q;
    assign bus.shell     = shell_q;
    assign bus.turn      = turn_q;
    assign bus.busy      = busy_q;
    assign bus.hit_pulse = hit_q;
    assign bus.lives1    = lives1_q;
    assign bus.lives2    = lives2_q;
    assign bus.game_over = over_q;
    assign bus.winner    = winner_q;
endmodule

// File: tb/tb_shot_sequencer.sv
// tb/tb_shot_sequencer.sv - scoreboard bench for shot_sequencer against a positional game model
module tb_shot_sequencer;
    localparam int S = 4;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    shot_sequencer_if bus();

    shot_sequencer #(.STEP_CYCLES(S), .LIVES(3)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         dur;
        logic [39:0] traj;
        logic       hit;
        logic [1:0] l1;
        logic [1:0] l2;
        logic       turn;
        logic       over;
        logic       winner;
        logic [7:0] shell_after;
    } outcome_t;

    outcome_t sb[$];

    // Game model: tank positions as field indices, lives as integers.
    int p1, p2, l1, l2, turn_m, over_m, winner_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        p1 = 7; p2 = 0; l1 = 3; l2 = 3; turn_m = 0; over_m = 0; winner_m = 0;
    endtask

    function automatic logic [7:0] exp_shell();
        logic [7:0] v;
        if (over_m != 0) v = 8'd0;
        else if (turn_m != 0) v = 8'(1 << (p2 + 1));
        else v = 8'(1 << (p1 - 1));
        return v;
    endfunction

    task automatic check_static(input string tag);
        check({tag, ".tank1"}, 64'(bus.tank1_loc), 64'(1 << (p1 - 4)));
        check({tag, ".tank2"}, 64'(bus.tank2_loc), 64'(1 << p2));
        check({tag, ".shell"}, 64'(bus.shell), 64'(exp_shell()));
        check({tag, ".turn"}, 64'(bus.turn), 64'(turn_m));
        check({tag, ".lives1"}, 64'(bus.lives1), 64'(l1));
        check({tag, ".lives2"}, 64'(bus.lives2), 64'(l2));
        check({tag, ".busy"}, 64'(bus.busy), 64'd0);
        check({tag, ".hit"}, 64'(bus.hit_pulse), 64'd0);
        check({tag, ".over"}, 64'(bus.game_over), 64'(over_m));
        check({tag, ".winner"}, 64'(bus.winner), 64'(winner_m));
    endtask

    task automatic move(input bit left);
        @(negedge clk);
        bus.btn_left  = left;
        bus.btn_right = ~left;
        @(negedge clk);
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        if (over_m == 0) begin
            if (turn_m == 0) p1 = left ? ((p1 > 4) ? p1 - 1 : 4) : ((p1 < 7) ? p1 + 1 : 7);
            else             p2 = left ? ((p2 > 0) ? p2 - 1 : 0) : ((p2 < 3) ? p2 + 1 : 3);
        end
        check_static("move");
    endtask

    task automatic restart();
        @(negedge clk);
        bus.btn_fire = 1'b1;
        @(negedge clk);
        bus.btn_fire = 1'b0;
        model_reset();
        check_static("restart");
    endtask

    // Fires one shot from the active tank, predicts its whole round and queues the prediction.
    task automatic fire(input int pw, input bit noise);
        outcome_t o;
        int d, base, dir, landing, kk, pos, bound;
        bit seen_idle;
        d    = pw + 2;
        base = (turn_m != 0) ? p2 + 1 : p1 - 1;
        dir  = (turn_m != 0) ? 1 : -1;
        landing = base + dir * (d - 1);
        o.dur  = d * S + 1;
        o.traj = '0;
        for (int k = 0; k < 5; k++) begin
            if (k <= d) begin
                kk  = (k < d - 1) ? k : d - 1;
                pos = base + dir * kk;
                if (pos >= 0 && pos <= 7) o.traj[k*8 +: 8] = 8'(1 << pos);
            end
        end
        o.hit = (landing >= 0) && (landing <= 7) && (landing == ((turn_m != 0) ? p1 : p2));
        if (o.hit) begin
            if (turn_m != 0) l1--; else l2--;
            if (l1 == 0 || l2 == 0) begin
                over_m = 1;
                winner_m = turn_m;
            end
        end
        if (over_m == 0) turn_m = 1 - turn_m;
        o.l1 = 2'(l1); o.l2 = 2'(l2);
        o.turn = turn_m[0]; o.over = over_m[0]; o.winner = winner_m[0];
        o.shell_after = exp_shell();
        sb.push_back(o);

        @(negedge clk);
        bus.power    = 2'(pw);
        bus.btn_fire = 1'b1;
        if (noise) bus.btn_left = 1'b1;
        @(negedge clk);
        bus.btn_fire = 1'b0;
        bus.btn_left = 1'b0;
        seen_idle = 1'b0;
        bound = d * S + 20;
        for (int j = 0; j < bound && !seen_idle; j++) begin
            if (noise && j < d * S - 1) begin
                bus.btn_left  = 1'($urandom_range(0, 1));
                bus.btn_right = 1'($urandom_range(0, 1));
                bus.btn_fire  = 1'($urandom_range(0, 1));
                bus.power     = 2'($urandom_range(0, 3));
            end else begin
                bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_fire = 1'b0;
            end
            @(negedge clk);
            if (!bus.busy) seen_idle = 1'b1;
        end
        bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_fire = 1'b0;
        check("shot_completes", 64'(seen_idle), 64'd1);
        @(negedge clk);
        check_static("post_shot");
    endtask

    // Monitor: times each flight and compares the round outcome when busy drops.
    initial begin
        logic prev_busy;
        logic in_flight;
        int idx;
        logic [39:0] traj;
        outcome_t e;
        prev_busy = 1'b0; in_flight = 1'b0; idx = 0; traj = '0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                in_flight = 1'b0;
                prev_busy = 1'b0;
                if (bus.hit_pulse) check("hit_in_reset", 64'(bus.hit_pulse), 64'd0);
                continue;
            end
            if (bus.busy && !prev_busy) begin
                in_flight = 1'b1; idx = 0; traj = '0;
            end
            if (in_flight && bus.busy) begin
                if ((idx % S) == 0 && (idx / S) < 5) traj[(idx / S) * 8 +: 8] = bus.shell;
                idx++;
            end
            if (in_flight && !bus.busy) begin
                in_flight = 1'b0;
                if (sb.size() == 0) begin
                    check("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("flight_cycles", 64'(idx), 64'(e.dur));
                    check("trajectory", 64'(traj), 64'(e.traj));
                    check("hit_pulse", 64'(bus.hit_pulse), 64'(e.hit));
                    check("lives1", 64'(bus.lives1), 64'(e.l1));
                    check("lives2", 64'(bus.lives2), 64'(e.l2));
                    check("turn", 64'(bus.turn), 64'(e.turn));
                    check("game_over", 64'(bus.game_over), 64'(e.over));
                    check("winner", 64'(bus.winner), 64'(e.winner));
                    check("shell_after", 64'(bus.shell), 64'(e.shell_after));
                end
            end else if (bus.hit_pulse) begin
                check("stray_hit_pulse", 64'(bus.hit_pulse), 64'd0);
            end
            prev_busy = bus.busy;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int q, pw, guard, nmoves;
        bit found;
        bus.btn_fire = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.power = 2'd0;
        model_reset();
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (100) @(negedge clk);
        check_static("reset");

        // Walk P1 to its lower boundary, one beyond to test saturation.
        repeat (4) move(1'b1);

        // P1 at pos4, full power: flies off the low end, miss.
        fire(3, 1'b1);
        // P2 walks to pos3 and misses into P1's half.
        repeat (3) move(1'b0);
        fire(0, 1'b0);
        // P1 returns to pos7 and hits P2 at pos3 with power 2.
        repeat (3) move(1'b0);
        fire(2, 1'b0);

        // Randomised rounds.
        repeat (25) begin
            if (over_m != 0) restart();
            nmoves = $urandom_range(0, 3);
            for (int m = 0; m < nmoves; m++) move(1'($urandom_range(0, 1)));
            fire($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        if (over_m != 0) restart();

        // Reset in the middle of a flight, without queuing a prediction.
        @(negedge clk);
        bus.power = 2'd3; bus.btn_fire = 1'b1;
        @(negedge clk);
        bus.btn_fire = 1'b0;
        repeat (6) @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        model_reset();
        check_static("async_reset");
        @(posedge clk);
        #2 nrst = 1'b1;
        repeat (10) @(negedge clk);
        check_static("after_reset_release");

        // P2 scores three hits on P1 while P1 always misses.
        guard = 0;
        while (over_m == 0 && guard < 20) begin
            guard++;
            if (turn_m == 0) begin
                found = 1'b0; pw = 0;
                for (int c = 0; c < 4; c++) begin
                    if (!found && (p1 - 1 - (c + 1)) != p2) begin
                        found = 1'b1; pw = c;
                    end
                end
                fire(pw, 1'b0);
            end else begin
                q = (p1 - 2 < 3) ? p1 - 2 : 3;
                while (p2 < q) move(1'b0);
                while (p2 > q) move(1'b1);
                fire(p1 - q - 2, 1'b0);
            end
        end
        check("game_ended", 64'(over_m), 64'd1);
        check_static("over");
        move(1'b1);
        move(1'b0);
        restart();

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/shot_sequencer.md
Name: shot_sequencer

Overview:
Round-level controller for the two-tank artillery game on the 8-position LED field. It owns turn order, tank positions, power capture, shell flight timing, hit resolution, lives and game over. It drives the per-position shell display bits and the tank location nibbles consumed by the display logic. Tank 1 occupies positions 7..4 and tank 2 occupies positions 3..0.

Parameters:
STEP_CYCLES, 512, clk cycles per shell position step (at least 2).
LIVES, 3, starting lives per player (1..3).

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
btn_fire  input  1  single-cycle fire / restart pulse (already synchronised)
btn_left  input  1  single-cycle pulse; moves the active tank toward lower index
btn_right  input  1  single-cycle pulse; moves the active tank toward higher index
power  input  2  shot power 0..3, sampled on fire acceptance
tank1_loc  output  4  one-hot tank 1 position; bit i = field position 4+i
tank2_loc  output  4  one-hot tank 2 position; bit i = field position i
shell  output  8  one-hot shell position, or all-zero when hidden or off-field
turn  output  1  0 = player 1 active, 1 = player 2 active
busy  output  1  high in FLIGHT and IMPACT
hit_pulse  output  1  one-cycle pulse on a hit
lives1  output  2  player 1 remaining lives
lives2  output  2  player 2 remaining lives
game_over  output  1  high in OVER
winner  output  1  valid while game_over is high; 0 = player 1 won

Behaviour:
- Reset is asynchronous and all outputs are registered. Reset values: state=AIM, tank1_loc=4'b1000 (pos7), tank2_loc=4'b0001 (pos0), turn=0, shell=8'b0100_0000, busy=0, hit_pulse=0, lives1=lives2=LIVES, game_over=0, winner=0.
- Reset asserted mid-flight or in any state aborts immediately to the reset values.
- States: AIM, FLIGHT, IMPACT, OVER.
- AIM:
  - shell shows the position adjacent to the active tank: P1 tank pos minus 1, P2 tank pos plus 1.
  - btn_left/btn_right shift the active tank by one position within its half. The tank saturates at the half boundary (P1 4..7, P2 0..3). The opponent's tank never moves.
  - btn_fire latches dist = power + 2 (range 2..5), sets traveled=1, step timer=0, and enters FLIGHT. shell keeps its adjacent position.
  - Fire and move in the same cycle: fire wins and the move is dropped.
- FLIGHT:
  - The timer counts 0..STEP_CYCLES-1.
  - At timer = STEP_CYCLES-1: if traveled = dist, go to IMPACT. Otherwise traveled += 1 and shell steps one position (down for P1, up for P2).
  - A step beyond position 0 or 7 sets shell = 0. shell stays 0 and timing continues unchanged, so latency is independent of position.
  - All buttons are ignored in FLIGHT and IMPACT.
- Latency: fire accepted at edge t puts shell at distance 1 from t+1 and at distance d from t+1+(d-1)·STEP_CYCLES. IMPACT is entered at t+1+dist·STEP_CYCLES.
- IMPACT lasts one cycle.
  - Hit = (shell != 0) && shell equals the opponent's 8-bit location. Landing in the shooter's own half is a miss.
  - On the next edge for a hit: hit_pulse=1 for one cycle and the opponent's lives decrement.
  - If lives reach 0: go to OVER with winner = turn.
  - Otherwise (hit or miss): turn toggles, go to AIM, and shell shows the adjacent position of the new active tank.
- OVER: shell=0 and game_over=1. Move buttons are ignored. btn_fire restores all reset values except that the state goes to AIM (same edge).
- Lives never underflow. hit_pulse is never asserted outside the IMPACT→next transition.

Test Plan:
- Reset, then hold idle for 100 cycles → tank1_loc=1000, tank2_loc=0001, shell=0x40, turn=0, lives1=lives2=3, busy=0.
- Four btn_left pulses in AIM (turn=0) → tank1_loc 1000→0100→0010→0001→0001 (saturates at pos4); shell tracks it: 0x20, 0x10, 0x08, 0x08.
- STEP_CYCLES=4; P1 at pos7, P2 moved to pos3; fire with power=2 at edge t → shell 0x40, 0x20, 0x10, 0x08 at t+1, t+5, t+9, t+13. IMPACT entered at t+17, hit_pulse high for the one cycle after edge t+18, lives2=2, turn=1, shell=0x10.
- P1 at pos4, fire with power=3 → shell 0x08, 0x04, 0x02, 0x01, then 0x00. Miss with no hit_pulse, lives unchanged, turn toggles at t+22 (STEP_CYCLES=4). btn_left pulses during flight → tank1_loc unchanged.
- Three P2 hits on P1 → lives1 3→2→1→0, game_over=1, winner=1, shell=0. Fire in OVER → all reset values restored, game_over=0.
- Assert nrst low at t+6 of a flight → all outputs at reset values within the same cycle, with no hit_pulse on release.
